// File: rtl/io_pkg.sv
// Shared types and elaboration-time helpers for the board-input conditioner.
package io_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        STEP = 1'b1
    } io_mode_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: two-flop synchroniser, tick-sampled debounce counter,
// clean level register and registered edge pulses.
module debounce_channel
    import io_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_clean);
    assign w_accept = i_tick && w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Edge pulses update on the same edge as the clean level.
            r_rise  <= w_accept && r_sync2;
            r_fall  <= w_accept && !r_sync2;
            if (i_tick) begin
                if (!w_differ || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_accept) begin
                r_clean <= r_sync2;
            end
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/io_conditioner.sv
// Board-input front end: debounce prescaler, N_CH conditioning channels and the
// CPU clock-enable generator with run and single-step modes.
module io_conditioner
    import io_pkg::*;
#(
    parameter int unsigned N_CH         = 10,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned STABLE_TICKS = 8,
    parameter int unsigned RUN_DIV      = 5000000,
    parameter int unsigned STEP_CH      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] rawIn,
    input  logic            modeStep,
    output logic [N_CH-1:0] cleanOut,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            sampleTick,
    output logic            cpuEn
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PRESC_W  = cnt_width(TICK_DIV - 1);
    localparam int unsigned RUN_W    = cnt_width(RUN_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("io_conditioner: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("io_conditioner: STABLE_TICKS must be at least 1");
    end
    if (RUN_DIV < 1) begin : g_bad_run_div
        $error("io_conditioner: RUN_DIV must be at least 1");
    end
    if (STEP_CH >= N_CH) begin : g_bad_step_ch
        $error("io_conditioner: STEP_CH must select an existing channel");
    end

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick     = (r_presc == PRESC_LAST);
    assign sampleTick = w_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (reset),
            .i_raw  (rawIn[g]),
            .i_tick (w_tick),
            .o_clean(cleanOut[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
        );
    end

    logic       r_mode_s1;
    logic       r_mode_s2;
    io_mode_t   w_mode_req;
    io_mode_t   r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic       r_cpu_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_mode_s1 <= modeStep;
            r_mode_s2 <= r_mode_s1;
        end
    end

    assign w_mode_req = r_mode_s2 ? STEP : RUN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_run_cnt <= '0;
            r_cpu_en  <= 1'b0;
        end else if (w_mode_req != r_state) begin
            // Mode switch cycle: no enable, pending step edge is dropped.
            r_state   <= w_mode_req;
            r_run_cnt <= '0;
            r_cpu_en  <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (r_run_cnt == RUN_LAST) begin
                        r_run_cnt <= '0;
                        r_cpu_en  <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                        r_cpu_en  <= 1'b0;
                    end
                end
                STEP: begin
                    r_run_cnt <= '0;
                    r_cpu_en  <= rise[STEP_CH];
                end
            endcase
        end
    end

    assign cpuEn = r_cpu_en;

endmodule

// File: tb/tb_io_conditioner.sv
// Randomised and directed bench for io_conditioner against a cycle-level
// behavioural model of the conditioning and clock-enable rules.
module tb_io_conditioner;

    localparam int unsigned N_CH         = 10;
    localparam int unsigned CLK_HZ       = 100;
    localparam int unsigned TICK_HZ      = 25;
    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned STABLE_TICKS = 3;
    localparam int unsigned RUN_DIV      = 5;
    localparam int unsigned STEP_CH      = 8;
    localparam int unsigned LAT_BOUND    = 2 + STABLE_TICKS * TICK_DIV + 1;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] rawIn;
    logic            modeStep;
    logic [N_CH-1:0] cleanOut;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            sampleTick;
    logic            cpuEn;

    io_conditioner #(
        .N_CH        (N_CH),
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .STABLE_TICKS(STABLE_TICKS),
        .RUN_DIV     (RUN_DIV),
        .STEP_CH     (STEP_CH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rawIn     (rawIn),
        .modeStep  (modeStep),
        .cleanOut  (cleanOut),
        .rise      (rise),
        .fall      (fall),
        .sampleTick(sampleTick),
        .cpuEn     (cpuEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: n counts clock edges since reset release.
    int              n;
    int              entry;
    logic [N_CH-1:0] raw_q[$];
    logic            mode_q[$];
    int              streak[N_CH];
    logic [N_CH-1:0] m_clean, m_rise, m_fall;
    logic            m_tick, m_en, m_mode;

    always @(posedge clk) begin
        logic [N_CH-1:0] sync_v;
        logic            msync;
        logic            prev_rise8;
        if (reset) begin
            n = 0;
            entry = 0;
            raw_q = '{'0, '0};
            mode_q = '{1'b0, 1'b0};
            for (int c = 0; c < N_CH; c++) streak[c] = 0;
            m_clean = '0; m_rise = '0; m_fall = '0;
            m_tick = 1'b0; m_en = 1'b0; m_mode = 1'b0;
        end else begin
            n++;
            raw_q.push_front(rawIn);
            mode_q.push_front(modeStep);
            sync_v = raw_q[2];
            msync  = mode_q[2];
            void'(raw_q.pop_back());
            void'(mode_q.pop_back());
            prev_rise8 = m_rise[STEP_CH];
            if (msync != m_mode) begin
                m_mode = msync;
                entry  = n;
                m_en   = 1'b0;
            end else if (!m_mode) begin
                m_en = ((n - entry) % RUN_DIV == 0);
            end else begin
                m_en = prev_rise8;
            end
            m_rise = '0;
            m_fall = '0;
            if (((n - 1) % TICK_DIV) == TICK_DIV - 1) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (sync_v[c] == m_clean[c]) begin
                        streak[c] = 0;
                    end else begin
                        streak[c]++;
                        if (streak[c] == STABLE_TICKS) begin
                            m_clean[c] = sync_v[c];
                            m_rise[c]  = sync_v[c];
                            m_fall[c]  = !sync_v[c];
                            streak[c]  = 0;
                        end
                    end
                end
            end
            m_tick = ((n % TICK_DIV) == TICK_DIV - 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("model_clean", 32'(cleanOut), 32'(m_clean));
            check("model_rise", 32'(rise), 32'(m_rise));
            check("model_fall", 32'(fall), 32'(m_fall));
            check("model_tick", 32'(sampleTick), 32'(m_tick));
            check("model_cpuen", 32'(cpuEn), 32'(m_en));
        end
    end

    initial begin
        int found;
        int cnt;
        int last;
        int rise_at;
        rawIn    = '0;
        modeStep = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Ticks on every fourth edge, channels quiet.
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("tick_literal", 32'(sampleTick), 32'((i % 4) == 3));
            check("quiet_outputs", 32'({cleanOut, rise, fall}), 32'd0);
        end

        // Clean press and release on channel 0.
        rawIn[0] = 1'b1;
        found = 0;
        for (int i = 1; i <= LAT_BOUND && found == 0; i++) begin
            @(negedge clk);
            if (cleanOut[0]) begin
                found = i;
                check("rise0_with_clean", 32'(rise[0]), 32'd1);
                check("fall0_on_press", 32'(fall[0]), 32'd0);
            end
        end
        check("press0_in_bound", 32'(found > 0), 32'd1);
        @(negedge clk);
        check("rise0_one_cycle", 32'(rise[0]), 32'd0);
        rawIn[0] = 1'b0;
        found = 0;
        for (int i = 1; i <= LAT_BOUND && found == 0; i++) begin
            @(negedge clk);
            if (!cleanOut[0]) begin
                found = i;
                check("fall0_with_clean", 32'(fall[0]), 32'd1);
                check("rise0_on_release", 32'(rise[0]), 32'd0);
            end
        end
        check("release0_in_bound", 32'(found > 0), 32'd1);
        @(negedge clk);
        check("fall0_one_cycle", 32'(fall[0]), 32'd0);

        // Bouncing channel 1: never three consecutive high samples.
        cnt = 0;
        for (int r = 0; r < 5; r++) begin
            rawIn[1] = 1'b1;
            repeat (2 * TICK_DIV) begin
                @(negedge clk);
                if (cleanOut[1] || rise[1]) cnt++;
            end
            rawIn[1] = 1'b0;
            repeat (TICK_DIV) begin
                @(negedge clk);
                if (cleanOut[1] || rise[1]) cnt++;
            end
        end
        check("bounce1_rejected", 32'(cnt), 32'd0);

        // Run mode: fixed spacing, step button ignored.
        last = -1;
        cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 12) rawIn[STEP_CH] = 1'b1;
            if (cpuEn) begin
                if (last >= 0) check("run_gap", 32'(i - last), 32'd5);
                last = i;
                cnt++;
            end
        end
        check("run_pulse_count", 32'(cnt), 32'd8);
        rawIn[STEP_CH] = 1'b0;
        repeat (20) @(negedge clk);

        // Step mode: one enable per clean press, one cycle after rise.
        modeStep = 1'b1;
        repeat (6) @(negedge clk);
        cnt = 0;
        rise_at = -10;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                rawIn[STEP_CH] = (i < 20);
                if (cpuEn) begin
                    cnt++;
                    check("step_lag", 32'(p * 40 + i - rise_at), 32'd1);
                end
                if (rise[STEP_CH]) rise_at = p * 40 + i;
            end
        end
        check("step_pulse_count", 32'(cnt), 32'd2);

        // Back to run mode: first enable five edges after the switch edge.
        modeStep = 1'b0;
        found = 0;
        for (int i = 1; i <= 12 && found == 0; i++) begin
            @(negedge clk);
            if (cpuEn) found = i;
        end
        check("run_restart_delay", 32'(found), 32'd8);

        // Reset in the middle of a debounce.
        rawIn[2] = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (streak[2] == 2) found = 1;
        end
        check("mid_debounce_reached", 32'(found), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs_zero", 32'({cleanOut, rise, fall, sampleTick, cpuEn}), 32'd0);
        end
        reset = 1'b0;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            @(negedge clk);
            if (rise[2]) found = i;
        end
        check("fresh_debounce_after_reset", 32'(found), 32'd12);

        // Random traffic on all channels and the mode input.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(23, 0) == 0) rawIn[c] = ~rawIn[c];
            end
            if ($urandom_range(149, 0) == 0) modeStep = ~modeStep;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
